alu_op_issue_stage: RTL and testbench
=====================================

// Module: alu_op_issue_stage
// PURPOSE
//  Issue stage directly upstream of the per-bit ALU result mux. Accepts (opcode, A, B)
//  words over valid/ready, then registers and presents them to the ALU datapath as
//  4-bit select S, operands A/B and a 10-bit one-hot op vector.
//  A 2-entry skid buffer decouples the producer from ALU back-pressure with full throughput.
// PARAMETERS
//  WIDTH   8  operand width in bits
//  CNT_W   16 width of issued-operation counter
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      producer has a word
//  in_ready     out  1      stage can accept a word this cycle
//  in_op        in   4      opcode: 0 ADD 1 SUB 2 AND 3 OR 4 NOT 5 XOR 6 LSL 7 LSR 8 ASL 9 ASR
//  in_a         in   WIDTH  operand A
//  in_b         in   WIDTH  operand B
//  out_valid    out  1      S/A/B/onehot valid for the ALU
//  out_ready    in   1      ALU/writeback consumes this cycle
//  out_sel      out  4      select S to the result mux (S[0] = LSB of opcode)
//  out_a        out  WIDTH  operand A
//  out_b        out  WIDTH  operand B
//  out_onehot   out  10     bit k set iff out_sel==k (k=0..9); all-zero for 10..15
//  illegal_op   out  1      sticky illegal-opcode flag (only with macro; else tied 0)
//  issue_count  out  CNT_W  number of completed out handshakes
// BEHAVIOUR
//  - Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready.
//  - Registers: main slot (drives out_*), skid slot. States EMPTY/HALF/FULL.
//    EMPTY: accept -> HALF (word goes to main).
//    HALF : accept & ~issue -> FULL (word to skid); issue & ~accept -> EMPTY;
//           accept & issue -> HALF (new word replaces main).
//    FULL : issue -> HALF (skid moves to main); accept impossible (in_ready=0).
//  - in_ready registered: 1 in EMPTY/HALF, 0 in FULL. out_valid = state != EMPTY.
//  - Latency: word accepted in cycle N visible on out_* in cycle N+1 (empty stage).
//  - Throughput 1 word/cycle while out_ready=1; strict FIFO order, no loss/duplication.
//  - out_* stable while out_valid & ~out_ready (held until issue).
//  - out_onehot derived from the registered opcode, never from in_op.
//  - issue_count += 1 per issue, wraps 2^CNT_W-1 -> 0 silently.
//  - Reset (rst=1 at clock edge): state EMPTY; in_ready=0, out_valid=0, out_sel=0,
//    out_a=0, out_b=0, out_onehot=0, illegal_op=0, issue_count=0. in_ready rises the
//    first edge after rst deasserts. Reset mid-transfer discards both slots;
//    in-flight words are lost, no handshake is counted in the reset cycle.
//  - Opcodes 10..15 without macro: passed through like any other; ALU mux yields 0.
// CONFIGURATION
//  ALU_ILLEGAL_OP_TRAP_EN
//   defined  : accept of in_op>=10 completes the input handshake but the word is
//              dropped (no state change, never issued); illegal_op set next cycle,
//              sticky until rst. issue_count unaffected.
//   undefined: no trap logic; illegal_op tied 0; opcodes 10..15 issued normally.
// TESTING
//  1 rst 2 cycles, release -> all outputs 0, in_ready=1 one cycle after release.
//  2 in op=0 a=8'h12 b=8'h34, out_ready=1 -> next cycle out_sel=0, onehot=10'h001,
//    a/b echoed; issue_count=1.
//  3 out_ready=0, push ops 3,5 -> second accept fills skid, in_ready=0, out_sel=3 held;
//    out_ready=1 -> issue 3 then 5, in_ready back to 1.
//  4 stream ops 0..9 back-to-back, out_ready=1 -> 10 issues in 10 consecutive
//    cycles, order preserved, onehot walks 1<<k, issue_count=10.
//  5 op=4'hC: macro on -> not issued, illegal_op=1 sticky; macro off -> issued,
//    out_onehot=0.
//  6 FULL, assert rst with out_ready=1 -> next cycle out_valid=0, issue_count unchanged by
//    reset cycle then 0; CNT_W=4 run 17 issues -> issue_count=1 (wrap).

Source files
------------

// File: rtl/alu_op_issue_stage.sv
// Issue stage: 2-entry skid buffer feeding the ALU with registered select, operands and one-hot op vector.
// Optional trap for opcodes 10..15 is enabled by defining ALU_ILLEGAL_OP_TRAP_EN.
module alu_op_issue_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [9:0]       out_onehot,
    output logic             illegal_op,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } word_t;

    state_t           state_q, state_d;
    word_t            main_q, main_d;
    word_t            skid_q, skid_d;
    word_t            in_word;
    logic             in_ready_q;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, issue, legal, take;

    assign in_word = '{op: in_op, a: in_a, b: in_b};
    assign accept  = in_valid & in_ready_q;
    assign issue   = (state_q != EMPTY) & out_ready;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    // Illegal words still complete the input handshake but never enter the buffer.
    assign legal     = (in_op < 4'd10);
    assign illegal_d = illegal_q | (accept & ~legal);
`else
    assign legal     = 1'b1;
    assign illegal_d = 1'b0;
`endif

    assign take = accept & legal;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (take) begin
                    main_d  = in_word;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (take && !issue) begin
                    skid_d  = in_word;
                    state_d = FULL;
                end else if (issue && !take) begin
                    state_d = EMPTY;
                end else if (take && issue) begin
                    main_d  = in_word;
                end
            end
            FULL: begin
                if (issue) begin
                    main_d  = skid_q;
                    state_d = HALF;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_q + {{(CNT_W-1){1'b0}}, issue};
        end
    end

    always_comb begin
        out_onehot = '0;
        for (int unsigned k = 0; k < 10; k++) begin
            out_onehot[k] = (main_q.op == 4'(k));
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_sel     = main_q.op;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign illegal_op  = illegal_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Randomized and directed bench for alu_op_issue_stage, checked every cycle against a queue model.
module tb_alu_op_issue_stage;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, out_valid, out_ready, illegal_op;
    logic [3:0]       in_op, out_sel;
    logic [WIDTH-1:0] in_a, in_b, out_a, out_b;
    logic [9:0]       out_onehot;
    logic [CNT_W-1:0] issue_count;

    always #5 clk = ~clk;

    alu_op_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .out_a(out_a), .out_b(out_b),
        .out_onehot(out_onehot), .illegal_op(illegal_op),
        .issue_count(issue_count)
    );

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } word_t;

    word_t q[$];
    word_t m_shown;
    bit    m_rdy;
    bit    m_ill;
    int    m_cnt;
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a FIFO of at most two words; the head is what the ALU sees.
    task automatic model_update();
        bit acc, iss;
        if (rst) begin
            q.delete();
            m_rdy   = 1'b0;
            m_ill   = 1'b0;
            m_cnt   = 0;
            m_shown = '{op: '0, a: '0, b: '0};
        end else begin
            acc = in_valid && m_rdy;
            iss = (q.size() != 0) && out_ready;
            if (iss) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (acc) begin
                if (TRAP && in_op >= 4'd10) m_ill = 1'b1;
                else q.push_back('{op: in_op, a: in_a, b: in_b});
            end
            m_rdy = (q.size() < 2);
            if (q.size() != 0) m_shown = q[0];
        end
    endtask

    task automatic compare();
        logic [9:0] oh;
        oh = '0;
        if (m_shown.op < 4'd10) oh[m_shown.op] = 1'b1;
        check("in_ready",    32'(in_ready),    32'(m_rdy));
        check("out_valid",   32'(out_valid),   32'(q.size() != 0));
        check("out_sel",     32'(out_sel),     32'(m_shown.op));
        check("out_a",       32'(out_a),       32'(m_shown.a));
        check("out_b",       32'(out_b),       32'(m_shown.b));
        check("out_onehot",  32'(out_onehot),  32'(oh));
        check("illegal_op",  32'(illegal_op),  32'(m_ill));
        check("issue_count", 32'(issue_count), 32'(m_cnt));
    endtask

    task automatic step(input logic r, input logic iv, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic ordy);
        rst = r; in_valid = iv; in_op = op; in_a = a; in_b = b; out_ready = ordy;
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset for two cycles, then release.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(issue_count), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word, one-cycle latency.
        step(0, 1, 4'd0, 8'h12, 8'h34, 1);
        check("t2_sel", 32'(out_sel), 32'd0);
        check("t2_onehot", 32'(out_onehot), 32'h001);
        check("t2_a", 32'(out_a), 32'h12);
        check("t2_b", 32'(out_b), 32'h34);
        step(0, 0, 0, 0, 0, 1);
        check("t2_count", 32'(issue_count), 32'd1);

        // Back-pressure fills the skid slot.
        step(0, 1, 4'd3, 8'hA1, 8'hB1, 0);
        step(0, 1, 4'd5, 8'hA2, 8'hB2, 0);
        check("t3_full_rdy", 32'(in_ready), 32'd0);
        check("t3_hold_sel", 32'(out_sel), 32'd3);
        step(0, 0, 0, 0, 0, 0);
        check("t3_still_sel", 32'(out_sel), 32'd3);
        step(0, 0, 0, 0, 0, 1);
        check("t3_next_sel", 32'(out_sel), 32'd5);
        check("t3_rdy_back", 32'(in_ready), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("t3_count", 32'(issue_count), 32'd3);

        // Stream opcodes 0..9 back-to-back.
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 4'(k), 8'(k * 3), 8'(k * 7), 1);
            check("t4_sel", 32'(out_sel), 32'(k));
            check("t4_onehot", 32'(out_onehot), 32'(1 << k));
        end
        step(0, 0, 0, 0, 0, 1);
        check("t4_count", 32'(issue_count), 32'd13);

        // Opcode 12.
        step(0, 1, 4'hC, 8'h55, 8'hAA, 0);
        if (TRAP) begin
            check("t5_trap_valid", 32'(out_valid), 32'd0);
            check("t5_trap_flag", 32'(illegal_op), 32'd1);
        end else begin
            check("t5_pass_valid", 32'(out_valid), 32'd1);
            check("t5_pass_onehot", 32'(out_onehot), 32'd0);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset while full and the ALU is ready.
        step(0, 1, 4'd1, 8'h01, 8'h02, 0);
        step(0, 1, 4'd2, 8'h03, 8'h04, 0);
        step(1, 0, 0, 0, 0, 1);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_count", 32'(issue_count), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 17; k++) step(0, 1, 4'(k % 10), 8'(k), 8'(~k), 1);
        step(0, 0, 0, 0, 0, 1);
        check("t6_wrap", 32'(issue_count), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
